mips_boot_loader: RTL and testbench
===================================

# mips_boot_loader

Boot-time program loader that sits directly upstream of the MIPS processor core and drives its `init`/`init_addr`/`init_data` initialisation port. It accepts a framed stream of 32-bit words over a valid/ready handshake and writes the payload into consecutive core addresses starting at 0. It holds the core in reset for the whole load, then releases it to run.

## Interface
Parameters:
- `ADDR_W`, default 8: width of `init_addr`; equals the core's init address width.
- `MAX_WORDS`, default 256: largest legal payload length; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; one clock and synchronous active-high reset are fixed for this block.
- `start`  in  1: single-cycle request to begin a load.
- `s_valid`  in  1: stream word valid.
- `s_ready`  out  1: loader can accept a word.
- `s_data`  in  32: stream word.
- `init`  out  1: write strobe to the core init port.
- `init_addr`  out  ADDR_W: core init address.
- `init_data`  out  32: core init data.
- `cpu_reset`  out  1: drives the core's `reset`.
- `busy`  out  1: a load is in progress.
- `done`  out  1: load completed; core running.
- `error`  out  1: frame rejected.
- `word_count`  out  ADDR_W+1: payload words accepted in the current frame.

## Operation
- Handshake: a word is accepted in any cycle with `s_valid & s_ready`. `s_ready` depends on state only, never on `s_valid`. `s_data` is ignored when not accepted.
- Frame format:
  - Header word: `[31:16]` = 16'hB007 magic, `[15:0]` = N.
  - Followed by N payload words.
  - Followed by one checksum word if configured.
- States:
  - IDLE: `s_ready`=0, `cpu_reset`=1. `start` → HEADER.
  - HEADER: `s_ready`=1. On accept:
    - Bad magic, N=0, or N>MAX_WORDS → FAULT.
    - Otherwise latch N, clear `word_count` and the running sum → LOAD.
  - LOAD: `s_ready`=1. Each accept:
    - Registers `init_data`=`s_data` and `init_addr`=`word_count[ADDR_W-1:0]`, and pulses `init` in the next cycle.
    - Increments `word_count` and adds the word to the running sum mod 2^32.
    - On the Nth accept → DRAIN (or CHECK, see Configuration).
  - DRAIN: `s_ready`=0 for one cycle while the final `init` pulse is issued → RUN.
  - RUN: `cpu_reset`=0, `done`=1. `start` → HEADER.
  - FAULT: `s_ready`=0, `cpu_reset`=1, `error`=1. `start` → HEADER.
- `busy`=1 in HEADER, LOAD, DRAIN, CHECK.
- `start` is ignored in HEADER, LOAD, DRAIN, and CHECK.
- `error` and `done` clear on leaving FAULT and RUN respectively.
- `init` is never asserted outside the cycle following a payload accept.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_reset`=1, `init`=0, `init_addr`=0, `init_data`=0, `s_ready`=0.
  - `busy`=0, `done`=0, `error`=0, `word_count`=0.
- `reset` mid-load aborts immediately to IDLE with these values. The partial image is left in the core.
- `start` in cycle t: `s_ready`=1 from cycle t+1.
- Payload accept in cycle t: `init`=1 with matching address and data in cycle t+1. `init_addr` and `init_data` hold their last values when `init`=0.
- Last payload accepted at cycle t, no checksum: DRAIN at t+1, RUN with `cpu_reset`=0 from t+2.
- Back-to-back accepts give one `init` per cycle with no bubbles. Gaps in `s_valid` only stall the load.
- `start` in RUN at cycle t: `cpu_reset`=1 from t+1 and `done`=0 from t+1.

## Configuration
- `MIPS_BOOT_LOADER_CHECKSUM_EN` defined:
  - After the Nth payload word, LOAD → CHECK, with `s_ready`=1 in CHECK.
  - The accepted checksum word is compared with the running sum: equal → RUN next cycle; unequal → FAULT next cycle.
  - CHECK's earliest accept is one cycle after the last payload accept, so the final `init` has already completed.
- Undefined: no CHECK state, no running-sum register; LOAD → DRAIN → RUN as above.

## Test plan
- Reset, then `start`, header 32'hB007_0003, payload 11,22,33 with `s_valid` held high → `init` pulses at addr 0,1,2 with 11,22,33 on consecutive cycles; `cpu_reset` falls two cycles after the last accept; `done`=1, `word_count`=3.
- Header 32'hB006_0004 → FAULT: `error`=1, `cpu_reset`=1, no `init` pulse. Header 32'hB007_0000 and 32'hB007_0101 (N=257) also → FAULT.
- N=256 with random `s_valid` gaps → 256 `init` pulses with addr 0..255 in order; addr wraps nowhere; data matches; `done`=1.
- `reset` asserted after 2 of 5 payload words → next cycle IDLE, `busy`=0, `cpu_reset`=1; a following `start` and a full 5-word frame loads correctly from addr 0.
- `start` during RUN → `cpu_reset`=1 next cycle and a second frame loads. `start` during LOAD has no effect.
- With `MIPS_BOOT_LOADER_CHECKSUM_EN`, payload 1,2,3:
  - Checksum 6 → RUN.
  - Checksum 7 → FAULT with `error`=1 and `cpu_reset` held high.

Source files
------------

// File: rtl/mips_boot_loader.sv
// Framed stream loader that writes a program image into the MIPS core init port.
// Optional checksum word support is enabled by defining MIPS_BOOT_LOADER_CHECKSUM_EN.
module mips_boot_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    output logic              init,
    output logic [ADDR_W-1:0] init_addr,
    output logic [31:0]       init_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        DRAIN,
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
        CHECK,
`endif
        RUN,
        FAULT
    } state_t;

    localparam logic [ADDR_W:0] WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state, state_next;
    logic [ADDR_W:0] frame_len;
    logic            accept;
    logic            header_ok;
    logic            last_word;
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
    logic [31:0]     sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        cpu_reset  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        header_ok  = (s_data[31:16] == 16'hB007) && (s_data[15:0] != 16'd0) &&
                     ({16'd0, s_data[15:0]} <= MAX_WORDS);
        last_word  = (word_count + WORD_ONE) == frame_len;
        case (state)
            IDLE: if (start) state_next = HEADER;
            HEADER: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) state_next = header_ok ? LOAD : FAULT;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
                if (s_valid && last_word) state_next = CHECK;
`else
                if (s_valid && last_word) state_next = DRAIN;
`endif
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = RUN;
            end
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
            CHECK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) state_next = (s_data == sum) ? RUN : FAULT;
            end
`endif
            RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) state_next = HEADER;
            end
            FAULT: begin
                error = 1'b1;
                if (start) state_next = HEADER;
            end
            default: state_next = IDLE;
        endcase
        accept = s_valid & s_ready;
    end

    // init pulses exactly one cycle after each payload accept; addr/data hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            init       <= 1'b0;
            init_addr  <= '0;
            init_data  <= '0;
            word_count <= '0;
            frame_len  <= '0;
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            init <= 1'b0;
            if (state == HEADER && accept) begin
                word_count <= '0;
                frame_len  <= s_data[ADDR_W:0];
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
                sum        <= '0;
`endif
            end
            if (state == LOAD && accept) begin
                init       <= 1'b1;
                init_addr  <= word_count[ADDR_W-1:0];
                init_data  <= s_data;
                word_count <= word_count + WORD_ONE;
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
                sum        <= sum + s_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed self-checking bench for mips_boot_loader (default and checksum builds).
module tb_mips_boot_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset, start, s_valid, s_ready;
    logic [31:0]       s_data, init_data;
    logic              init, cpu_reset, busy, done, error;
    logic [ADDR_W-1:0] init_addr;
    logic [ADDR_W:0]   word_count;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int unsigned addr_q[$], data_q[$], cyc_q[$], exp_q[$];
    int unsigned sum;

    mips_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .init(init), .init_addr(init_addr), .init_data(init_data),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (init) begin
            addr_q.push_back(32'(init_addr));
            data_q.push_back(init_data);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_q();
        addr_q.delete(); data_q.delete(); cyc_q.delete(); exp_q.delete();
        sum = 0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_ready", s_ready, 1);
    endtask

    // Present a word (after optional idle gap) and return right after the accepting edge.
    task automatic send(input logic [31:0] d, input int unsigned gap);
        int t;
        repeat (gap) begin @(negedge clk); s_valid = 1'b0; end
        @(negedge clk); s_valid = 1'b1; s_data = d;
        t = 0;
        while (!s_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic end_stream();
        @(negedge clk); s_valid = 1'b0; s_data = 32'hDEAD_BEEF;
    endtask

    task automatic send_payload(input int unsigned n, input int unsigned seed,
                                input int unsigned max_gap);
        int unsigned d;
        clear_q();
        send({16'hB007, 16'(n)}, 0);
        for (int unsigned i = 0; i < n; i++) begin
            d = seed * (i + 1);
            exp_q.push_back(d);
            sum += d;
            send(d, (max_gap != 0) ? $urandom_range(0, max_gap) : 0);
        end
    endtask

    task automatic send_checksum();
`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
        send(sum, 0);
`endif
    endtask

    task automatic check_image(input string tag);
        int bad = 0;
        check({tag, "_count"}, addr_q.size(), exp_q.size());
        for (int i = 0; i < addr_q.size() && i < exp_q.size(); i++)
            if (addr_q[i] != i || data_q[i] != exp_q[i]) bad++;
        check({tag, "_content"}, bad, 0);
    endtask

    initial begin
        logic [31:0] bad_hdr [3];
        bad_hdr[0] = 32'hB006_0004;
        bad_hdr[1] = 32'hB007_0000;
        bad_hdr[2] = 32'hB007_0101;
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        clear_q();
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_init", init, 0);
        check("rst_init_addr", init_addr, 0);
        check("rst_init_data", init_data, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_word_count", word_count, 0);
        reset = 1'b0;

        // Basic 3-word frame, s_valid held high.
        do_start();
        send_payload(3, 11, 0);
`ifndef MIPS_BOOT_LOADER_CHECKSUM_EN
        end_stream();
        check("drain_init", init, 1);
        check("drain_cpu_reset", cpu_reset, 1);
        check("drain_s_ready", s_ready, 0);
        check("drain_busy", busy, 1);
        @(negedge clk);
`else
        send_checksum();
        end_stream();
`endif
        check("run_cpu_reset", cpu_reset, 0);
        check("run_done", done, 1);
        check("run_busy", busy, 0);
        check("run_word_count", word_count, 3);
        @(negedge clk);
        check_image("basic");
        if (cyc_q.size() == 3) check("basic_back_to_back", cyc_q[2] - cyc_q[0], 2);
        else check("basic_cycles_size", cyc_q.size(), 3);

        // Rejected headers: bad magic, N=0, N=257.
        for (int k = 0; k < 3; k++) begin
            do_start();
            clear_q();
            send(bad_hdr[k], 0);
            end_stream();
            check($sformatf("fault%0d_error", k), error, 1);
            check($sformatf("fault%0d_cpu_reset", k), cpu_reset, 1);
            check($sformatf("fault%0d_s_ready", k), s_ready, 0);
            check($sformatf("fault%0d_busy", k), busy, 0);
            @(negedge clk);
            check($sformatf("fault%0d_no_init", k), addr_q.size(), 0);
        end

        // Full-size frame with random valid gaps.
        do_start();
        check("restart_error_cleared", error, 0);
        send_payload(256, 32'h0100_0193, 2);
        send_checksum();
        end_stream();
        repeat (2) @(negedge clk);
        check_image("n256");
        check("n256_done", done, 1);
        check("n256_word_count", word_count, 256);

        // Start in RUN, then reset after 2 of 5 words.
        do_start();
        check("rerun_cpu_reset", cpu_reset, 1);
        check("rerun_done", done, 0);
        clear_q();
        send(32'hB007_0005, 0);
        send(32'h1111_0000, 0);
        send(32'h2222_0000, 0);
        @(negedge clk); s_valid = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_s_ready", s_ready, 0);
        check("abort_init", init, 0);
        check("abort_word_count", word_count, 0);
        @(negedge clk);
        check("abort_idle_ready", s_ready, 0);
        do_start();
        send_payload(5, 5, 0);
        send_checksum();
        end_stream();
        repeat (2) @(negedge clk);
        check_image("after_abort");
        check("after_abort_done", done, 1);

        // Start pulse during LOAD is ignored.
        do_start();
        clear_q();
        send(32'hB007_0002, 0);
        send(32'hCAFE_0001, 0);
        exp_q.push_back(32'hCAFE_0001);
        @(negedge clk); s_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("load_start_busy", busy, 1);
        check("load_start_word_count", word_count, 1);
        send(32'hCAFE_0002, 0);
        exp_q.push_back(32'hCAFE_0002);
        sum = 32'hCAFE_0001 + 32'hCAFE_0002;
        send_checksum();
        end_stream();
        repeat (2) @(negedge clk);
        check_image("load_start");
        check("load_start_done", done, 1);
        check("load_start_wc_final", word_count, 2);

`ifdef MIPS_BOOT_LOADER_CHECKSUM_EN
        do_start();
        clear_q();
        send(32'hB007_0003, 0);
        send(1, 0); send(2, 0); send(3, 0);
        send(6, 0);
        end_stream();
        check("csum_ok_done", done, 1);
        check("csum_ok_cpu_reset", cpu_reset, 0);
        do_start();
        send(32'hB007_0003, 0);
        send(1, 0); send(2, 0); send(3, 0);
        send(7, 0);
        end_stream();
        check("csum_bad_error", error, 1);
        check("csum_bad_cpu_reset", cpu_reset, 1);
        check("csum_bad_done", done, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
